// File: rtl/correlator_bank.sv
// correlator_bank: per-pair bit-agreement correlator over a window of samples.
// Each pair of channels accumulates the number of equal bit positions across
// WINDOW accepted sample sets. The total is then held until the consumer
// takes it.
module correlator_bank #(
  parameter int WIDTH    = 10,
  parameter int CHANNELS = 3,
  parameter int WINDOW   = 4,
  localparam int PAIRS   = CHANNELS * (CHANNELS - 1) / 2,
  localparam int ACC_W   = $clog2(WIDTH * WINDOW + 1),
  localparam int CNT_W   = $clog2(WINDOW + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PAIRS*ACC_W-1:0]    out_data,
  output logic [CNT_W-1:0]          sample_count
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t                   state, state_next;
  logic [PAIRS*ACC_W-1:0]   acc, acc_next;
  logic [PAIRS*ACC_W-1:0]   corr;
  logic [CNT_W-1:0]         count, count_next;
  logic                     started;
  logic                     accept;
  logic                     handshake;

  // Build one popcount-of-XNOR unit per channel pair, in lexicographic (i,j) order
  for (genvar i = 0; i < CHANNELS; i++) begin : g_row
    for (genvar j = i + 1; j < CHANNELS; j++) begin : g_pair
      localparam int K = i * (2 * CHANNELS - i - 1) / 2 + (j - i - 1);
      logic [WIDTH-1:0] eq;
      logic [ACC_W-1:0] pop;

      assign eq = ~(in_data[i*WIDTH +: WIDTH] ^ in_data[j*WIDTH +: WIDTH]);

      // Count the bit positions where the two channels agree
      always_comb begin
        pop = '0;
        for (int b = 0; b < WIDTH; b++) begin
          pop = pop + ACC_W'(eq[b]);
        end
      end

      assign corr[K*ACC_W +: ACC_W] = pop;
    end
  end

  // Keep in_ready low until the first clock edge after reset
  assign in_ready     = (state == ACCUM) && started;
  assign out_valid    = (state == HOLD);
  assign out_data     = acc;
  assign sample_count = count;
  assign accept       = in_valid && in_ready;
  assign handshake    = out_valid && out_ready;

  // Next-state logic: clear wins, then accept in ACCUM, then handshake in HOLD
  always_comb begin
    state_next = state;
    acc_next   = acc;
    count_next = count;
    if (clear) begin
      state_next = ACCUM;
      acc_next   = '0;
      count_next = '0;
    end else if (state == ACCUM) begin
      if (accept) begin
        for (int k = 0; k < PAIRS; k++) begin
          acc_next[k*ACC_W +: ACC_W] = acc[k*ACC_W +: ACC_W] + corr[k*ACC_W +: ACC_W];
        end
        count_next = count + 1'b1;
        if (count == CNT_W'(WINDOW - 1)) begin
          state_next = HOLD;
        end
      end
    end else if (handshake) begin
      state_next = ACCUM;
      acc_next   = '0;
      count_next = '0;
    end
  end

  // State, accumulator and sample counter registers with async reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ACCUM;
      acc     <= '0;
      count   <= '0;
      started <= 1'b0;
    end else begin
      state   <= state_next;
      acc     <= acc_next;
      count   <= count_next;
      started <= 1'b1;
    end
  end

endmodule

// File: tb/tb_correlator_bank.sv
// tb_correlator_bank: table-driven, hand-sequenced and random checks of
// correlator_bank against a transaction-level model. The model keeps the
// accepted samples in a queue and sums their per-pair bit agreement.
module tb_correlator_bank;

  localparam int WIDTH = 10;
  localparam int CHANNELS = 3;
  localparam int WINDOW = 4;
  localparam int ACC_W = 6;
  localparam int CNT_W = 3;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
  } sample_t;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    int ab;
    int ac;
    int bc;
  } vec_t;

  logic clk;
  logic reset;
  logic clear;
  logic in_valid;
  logic in_ready;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [3*ACC_W-1:0] out_data;
  logic [CNT_W-1:0] sample_count;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] c_in;

  int tests_run;
  int tests_failed;

  sample_t model_q[$];
  logic model_hold;
  logic model_started;

  vec_t vecs[4];

  assign in_data = {c_in, b_in, a_in};

  correlator_bank #(
    .WIDTH(WIDTH),
    .CHANNELS(CHANNELS),
    .WINDOW(WINDOW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .sample_count(sample_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3*ACC_W-1:0] expected_data();
    int s0;
    int s1;
    int s2;
    s0 = 0;
    s1 = 0;
    s2 = 0;
    foreach (model_q[n]) begin
      s0 += $countones(~(model_q[n].a ^ model_q[n].b));
      s1 += $countones(~(model_q[n].a ^ model_q[n].c));
      s2 += $countones(~(model_q[n].b ^ model_q[n].c));
    end
    return {ACC_W'(s2), ACC_W'(s1), ACC_W'(s0)};
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] c,
                               input logic ordy, input logic clr);
    in_valid  = v;
    a_in      = a;
    b_in      = b;
    c_in      = c;
    out_ready = ordy;
    clear     = clr;
  endtask

  task automatic modelReset();
    model_q.delete();
    model_hold    = 1'b0;
    model_started = 1'b0;
  endtask

  // Compare every visible output with the model's view of the block
  task automatic checkAll();
    checkOutput("in_ready", int'(in_ready), int'(model_started && !model_hold));
    checkOutput("out_valid", int'(out_valid), int'(model_hold));
    checkOutput("sample_count", int'(sample_count), model_q.size());
    if (model_hold || !model_started) begin
      checkOutput("out_data", int'(out_data), int'(expected_data()));
    end
  endtask

  // Advance one clock edge, update the model from the inputs seen at that edge
  task automatic tick();
    logic accept;
    logic handshake;
    @(posedge clk);
    accept    = in_valid && model_started && !model_hold;
    handshake = model_hold && out_ready;
    if (clear) begin
      model_q.delete();
      model_hold = 1'b0;
    end else if (accept) begin
      model_q.push_back('{a: a_in, b: b_in, c: c_in});
      if (model_q.size() == WINDOW) model_hold = 1'b1;
    end else if (handshake) begin
      model_q.delete();
      model_hold = 1'b0;
    end
    model_started = 1'b1;
    #1;
    checkAll();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    vecs[0] = '{a: 10'h3FF, b: 10'h3FF, c: 10'h3FF, ab: 40, ac: 40, bc: 40};
    vecs[1] = '{a: 10'h000, b: 10'h3FF, c: 10'h000, ab: 0,  ac: 40, bc: 0};
    vecs[2] = '{a: 10'h0F0, b: 10'h0FF, c: 10'h0F0, ab: 24, ac: 40, bc: 24};
    vecs[3] = '{a: 10'h155, b: 10'h2AA, c: 10'h155, ab: 0,  ac: 40, bc: 0};

    // Reset held before any clock edge
    reset = 1'b1;
    modelReset();
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
    #1;
    checkAll();
    #2;
    reset = 1'b0;
    #1;
    checkOutput("in_ready_before_first_edge", int'(in_ready), 0);
    tick();

    // Table-driven windows with out_ready held high throughout
    for (int e = 0; e < 4; e++) begin
      for (int s = 0; s < WINDOW; s++) begin
        applyStimulus(1'b1, vecs[e].a, vecs[e].b, vecs[e].c, 1'b1, 1'b0);
        tick();
      end
      checkOutput("tbl_out_valid", int'(out_valid), 1);
      checkOutput("tbl_ab", int'(out_data[0*ACC_W +: ACC_W]), vecs[e].ab);
      checkOutput("tbl_ac", int'(out_data[1*ACC_W +: ACC_W]), vecs[e].ac);
      checkOutput("tbl_bc", int'(out_data[2*ACC_W +: ACC_W]), vecs[e].bc);
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0);
      tick();
    end

    // Backpressure: result stays put while out_ready is low and inputs change
    for (int s = 0; s < WINDOW; s++) begin
      applyStimulus(1'b1, 10'h000, 10'h3FF, 10'h000, 1'b0, 1'b0);
      tick();
    end
    for (int s = 0; s < 5; s++) begin
      applyStimulus(1'b1, 10'($urandom), 10'($urandom), 10'($urandom), 1'b0, 1'b0);
      tick();
      checkOutput("bp_ac", int'(out_data[1*ACC_W +: ACC_W]), 40);
      checkOutput("bp_count", int'(sample_count), WINDOW);
    end
    applyStimulus(1'b1, 10'h3FF, 10'h3FF, 10'h3FF, 1'b1, 1'b0);
    tick();
    checkOutput("bp_release_in_ready", int'(in_ready), 1);
    checkOutput("bp_release_count", int'(sample_count), 0);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
    tick();

    // Clear mid-window discards the first two samples
    for (int s = 0; s < 2; s++) begin
      applyStimulus(1'b1, 10'h3FF, 10'h3FF, 10'h3FF, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 10'h3FF, 10'h3FF, 10'h3FF, 1'b0, 1'b1);
    tick();
    for (int s = 0; s < WINDOW; s++) begin
      applyStimulus(1'b1, 10'h000, 10'h3FF, 10'h3FF, 1'b0, 1'b0);
      tick();
    end
    checkOutput("clr_ab", int'(out_data[0*ACC_W +: ACC_W]), 0);
    checkOutput("clr_ac", int'(out_data[1*ACC_W +: ACC_W]), 0);
    checkOutput("clr_bc", int'(out_data[2*ACC_W +: ACC_W]), 40);

    // Async reset between edges while holding a result
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    modelReset();
    #1;
    checkOutput("arst_out_valid", int'(out_valid), 0);
    checkOutput("arst_out_data", int'(out_data), 0);
    checkOutput("arst_count", int'(sample_count), 0);
    #1;
    reset = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
    end

    // Gapped input: four accepts over eight cycles
    for (int s = 0; s < 8; s++) begin
      applyStimulus(s % 2 == 0, 10'h0F0, 10'h0FF, 10'h0F0, 1'b0, 1'b0);
      tick();
      if (s == 6) checkOutput("gap_valid_after_4th", int'(out_valid), 1);
      if (s == 5) checkOutput("gap_valid_before_4th", int'(out_valid), 0);
    end
    checkOutput("gap_count", int'(sample_count), WINDOW);
    checkOutput("gap_ab", int'(out_data[0*ACC_W +: ACC_W]), 24);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0);
    tick();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      applyStimulus(1'($urandom), 10'($urandom), 10'($urandom), 10'($urandom),
                    1'($urandom), ($urandom_range(0, 15) == 0));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/correlator_bank.md
CORRELATOR_BANK -- requirements
Module: correlator_bank

Interface
REQ-001 The block SHALL have a parameter WIDTH, default 10, giving the bits per channel sample.
REQ-002 The block SHALL have a parameter CHANNELS, default 3 (minimum 2), giving the number of input channels.
REQ-003 The block SHALL have a parameter WINDOW, default 4 (minimum 1), giving the accepted samples per correlation result.
REQ-004 Derived values SHALL be PAIRS = CHANNELS*(CHANNELS-1)/2 and ACC_W = clog2(WIDTH*WINDOW+1); with defaults, PAIRS=3 and ACC_W=6.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset; the ports are listed below.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 clear  input  1  synchronous abort: discard the current window.
REQ-009 in_valid  input  1  in_data holds a valid sample set.
REQ-010 in_ready  output  1  the block can accept a sample set this cycle.
REQ-011 in_data  input  CHANNELS*WIDTH  channel n occupies [n*WIDTH +: WIDTH].
REQ-012 out_valid  output  1  out_data holds a completed window result.
REQ-013 out_ready  input  1  the consumer accepts the result this cycle.
REQ-014 out_data  output  PAIRS*ACC_W  pair k occupies [k*ACC_W +: ACC_W].
REQ-015 sample_count  output  clog2(WINDOW+1)  samples accepted in the current window.

Function
REQ-016 Pair ordering SHALL be lexicographic over (i,j) with i<j: k=0 is (0,1), k=1 is (0,2), and so on; with 3 channels this gives ab, ac, bc.
REQ-017 Per-sample pair correlation SHALL equal the number of bit positions in which channel i and channel j are equal, i.e. the popcount of the XNOR, ranging from 0 to WIDTH.
REQ-018 A sample SHALL be accepted exactly on a rising clock edge where in_valid=1 and in_ready=1; on acceptance every pair accumulator adds its per-sample correlation and sample_count increments.
REQ-019 Accumulators SHALL be ACC_W bits wide and SHALL never overflow, since the maximum is WIDTH*WINDOW.
REQ-020 The FSM SHALL have two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-021 ACCUM->HOLD SHALL occur on the edge that accepts the WINDOW-th sample; out_valid SHALL rise in the next cycle, and out_data SHALL include that sample (latency: 1 cycle after the last accept).
REQ-022 In HOLD, out_data SHALL be stable, and in_data/in_valid SHALL be ignored.
REQ-023 HOLD->ACCUM SHALL occur on the edge where out_valid=1 and out_ready=1; on that edge the accumulators and sample_count clear to 0.
REQ-024 The block SHALL NOT accept a sample on the same edge as the output handshake; in_ready SHALL return to 1 the following cycle.
REQ-025 out_ready SHALL be ignored while out_valid=0.
REQ-026 clear=1 SHALL take priority over accept and handshake: on that edge the accumulators and sample_count go to 0, the state goes to ACCUM, and out_valid goes to 0 (any held result is dropped).
REQ-027 With WINDOW=1, every accepted sample SHALL produce a result after 1 cycle, using the same handshake.
REQ-028 sample_count SHALL read WINDOW while in HOLD.

Reset
REQ-029 While reset=1, independent of clk: state=ACCUM, all accumulators=0, sample_count=0, out_valid=0, out_data=0, in_ready=0.
REQ-030 After reset deasserts, in_ready SHALL be 1 from the first rising clk edge onward.
REQ-031 Reset asserted mid-window or in HOLD SHALL take effect immediately and lose all partial or held results.

Verification (defaults WIDTH=10, CHANNELS=3, WINDOW=4)
REQ-032 Four samples a=b=c=10'h3FF with out_ready=1 -> one cycle after the 4th accept, out_valid=1 and out_data = {bc=40, ac=40, ab=40}.
REQ-033 Four samples a=10'h000, b=10'h3FF, c=10'h000 -> ab=0, ac=40, bc=0; and four samples a=10'h0F0, b=10'h0FF, c=10'h0F0 -> ab=24, ac=40, bc=24.
REQ-034 Backpressure: complete a window, then hold out_ready=0 for 5 cycles while driving in_valid=1 with changing data -> out_valid=1, out_data unchanged, in_ready=0, sample_count=4 throughout; out_ready=1 for one cycle -> out_valid=0 next cycle and in_ready=1.
REQ-035 Clear mid-window: accept 2 samples of all-ones on a=b=c, pulse clear, then 4 samples a=10'h000, b=10'h3FF, c=10'h3FF -> result ab=0, ac=0, bc=40 (the earlier samples are excluded).
REQ-036 Async reset pulse between clock edges while in HOLD -> out_valid, out_data and sample_count go to 0 before the next edge, and no stale result appears after release.
REQ-037 Gapped input: in_valid toggles 1,0,1,0,... across 8 cycles -> exactly 4 accepts, and the result appears 1 cycle after the 4th accept.
